// File: rtl/screen_ram_writer_pkg.sv
// Shared address map, FSM states and nibble helper for the packed 4bpp screen RAM.
// The display read path uses this package as well, so both sides agree on the pixel layout.
package screen_ram_writer_pkg;

    localparam int SCREEN_WIDTH  = 11;
    localparam int ADDR_WIDTH    = 25;
    localparam int DATA_WIDTH    = 32;
    localparam int START_ADDR    = 0;
    localparam int WIDTH         = 488;
    localparam int HEIGHT        = 280;
    localparam int WST           = 76;
    localparam int HST           = 100;
    localparam int WORDS_PER_ROW = WIDTH / 8;
    localparam int FRAME_WORDS   = HEIGHT * WORDS_PER_ROW;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FILL
    } state_t;

    // WST is 4 mod 8, so the first drawable pixel of each word (x[2:0]=4) lands in nibble 0.
    function automatic logic [2:0] nibble_index(input logic [2:0] x_lo);
        return {~x_lo[2], x_lo[1:0]};
    endfunction

endpackage

// File: rtl/screen_ram_writer_if.sv
// Pixel request handshake plus the RAM port shared with the display reader.
interface screen_ram_writer_if #(
    parameter int SCREEN_WIDTH = screen_ram_writer_pkg::SCREEN_WIDTH,
    parameter int ADDR_WIDTH   = screen_ram_writer_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = screen_ram_writer_pkg::DATA_WIDTH
);

    logic                    req_valid;
    logic                    req_ready;
    logic [SCREEN_WIDTH-1:0] req_x;
    logic [SCREEN_WIDTH-1:0] req_y;
    logic [3:0]              req_color;

    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic                    ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    modport master (
        output req_valid, req_x, req_y, req_color, ram_rdata,
        input  req_ready, ram_addr, ram_re, ram_we, ram_wdata
    );

    modport slave (
        input  req_valid, req_x, req_y, req_color, ram_rdata,
        output req_ready, ram_addr, ram_re, ram_we, ram_wdata
    );

endinterface

// File: rtl/screen_ram_writer_pixel_addr_calc.sv
// Combinational pixel-to-word mapping: word address, nibble index and region test for (x, y).
module pixel_addr_calc
    import screen_ram_writer_pkg::*;
#(
    parameter int SCREEN_WIDTH = screen_ram_writer_pkg::SCREEN_WIDTH,
    parameter int ADDR_WIDTH   = screen_ram_writer_pkg::ADDR_WIDTH,
    parameter int START_ADDR   = screen_ram_writer_pkg::START_ADDR,
    parameter int WIDTH        = screen_ram_writer_pkg::WIDTH,
    parameter int HEIGHT       = screen_ram_writer_pkg::HEIGHT,
    parameter int WST          = screen_ram_writer_pkg::WST,
    parameter int HST          = screen_ram_writer_pkg::HST
) (
    input  logic [SCREEN_WIDTH-1:0] x,
    input  logic [SCREEN_WIDTH-1:0] y,
    output logic [ADDR_WIDTH-1:0]   word_addr,
    output logic [2:0]              nibble,
    output logic                    in_region
);

    // Three extra bits so the pixel offset never truncates before the >>3 to a word offset.
    localparam int PW = ADDR_WIDTH + 3;

    logic [PW-1:0] x_ext;
    logic [PW-1:0] y_ext;
    logic [PW-1:0] dx;
    logic [PW-1:0] dy;
    logic [PW-1:0] pixel_offset;

    assign x_ext = PW'(x);
    assign y_ext = PW'(y);

    assign in_region = (x_ext >= PW'(WST)) && (x_ext < PW'(WST + WIDTH)) &&
                       (y_ext >= PW'(HST)) && (y_ext < PW'(HST + HEIGHT));

    assign dx           = x_ext - PW'(WST);
    assign dy           = y_ext - PW'(HST);
    assign pixel_offset = dy * PW'(WIDTH) + dx;
    assign word_addr    = ADDR_WIDTH'(START_ADDR) + pixel_offset[PW-1:3];
    assign nibble       = nibble_index(x[2:0]);

endmodule

// File: rtl/screen_ram_writer.sv
// Screen RAM write engine: read-modify-write of single 4bpp pixels and a one-word-per-cycle
// region fill, both sharing the registered RAM port.
module screen_ram_writer
    import screen_ram_writer_pkg::*;
#(
    parameter int SCREEN_WIDTH = screen_ram_writer_pkg::SCREEN_WIDTH,
    parameter int ADDR_WIDTH   = screen_ram_writer_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = screen_ram_writer_pkg::DATA_WIDTH,
    parameter int START_ADDR   = screen_ram_writer_pkg::START_ADDR,
    parameter int WIDTH        = screen_ram_writer_pkg::WIDTH,
    parameter int HEIGHT       = screen_ram_writer_pkg::HEIGHT,
    parameter int WST          = screen_ram_writer_pkg::WST,
    parameter int HST          = screen_ram_writer_pkg::HST
) (
    input  logic                  clk,
    input  logic                  rst,
    screen_ram_writer_if.slave    bus,
    input  logic                  fill_start,
    input  logic [3:0]            fill_color,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int LAST_WORD = (HEIGHT * WIDTH / 8) - 1;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_next;
    logic                    re_q, re_next;
    logic                    we_q, we_next;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_next;
    logic                    done_q, done_next;
    logic                    err_q, err_next;
    logic [2:0]              nib_q, nib_next;
    logic [3:0]              color_q, color_next;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_next;

    logic [ADDR_WIDTH-1:0]   calc_addr;
    logic [2:0]              calc_nibble;
    logic                    calc_in_region;

    pixel_addr_calc #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .START_ADDR   (START_ADDR),
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .WST          (WST),
        .HST          (HST)
    ) u_addr_calc (
        .x         (bus.req_x),
        .y         (bus.req_y),
        .word_addr (calc_addr),
        .nibble    (calc_nibble),
        .in_region (calc_in_region)
    );

    assign bus.req_ready = (state == IDLE) && !fill_start;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_re    = re_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_wdata = wdata_q;
    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign err           = err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        addr_next  = addr_q;
        re_next    = 1'b0;
        we_next    = 1'b0;
        wdata_next = wdata_q;
        done_next  = 1'b0;
        err_next   = 1'b0;
        nib_next   = nib_q;
        color_next = color_q;
        cnt_next   = cnt_q;

        case (state)
            IDLE: begin
                if (fill_start) begin
                    wdata_next = {(DATA_WIDTH / 4){fill_color}};
                    addr_next  = ADDR_WIDTH'(START_ADDR);
                    cnt_next   = '0;
                    we_next    = 1'b1;
                    state_next = FILL;
                end else if (bus.req_valid) begin
                    if (calc_in_region) begin
                        addr_next  = calc_addr;
                        nib_next   = calc_nibble;
                        color_next = bus.req_color;
                        re_next    = 1'b1;
                        state_next = RD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RD: begin
                // First RD cycle still has the read strobe out; the word lands on the second.
                if (!re_q) begin
                    wdata_next                     = bus.ram_rdata;
                    wdata_next[{nib_q, 2'b00} +: 4] = color_q;
                    we_next                        = 1'b1;
                    state_next                     = WR;
                end
            end
            WR: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            FILL: begin
                if (cnt_q == ADDR_WIDTH'(LAST_WORD)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next  = cnt_q + 1'b1;
                    addr_next = ADDR_WIDTH'(START_ADDR) + cnt_next;
                    we_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            nib_q   <= '0;
            color_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_next;
            re_q    <= re_next;
            we_q    <= we_next;
            wdata_q <= wdata_next;
            done_q  <= done_next;
            err_q   <= err_next;
            nib_q   <= nib_next;
            color_q <= color_next;
            cnt_q   <= cnt_next;
        end
    end

endmodule
